// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline constants for the fetch/hazard control slice.
package mips_pkg;
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LDSTALL = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;
    localparam logic [31:0] NOP = 32'h0000_0000;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load in EX.
module load_use_detect #(
    parameter int RW = 5
) (
    input  logic          ex_is_load,
    input  logic [RW-1:0] ex_rd,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rt,
    output logic          load_use
);
    assign load_use = ex_is_load & (ex_rd != '0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
endmodule

// File: rtl/hazard_fetch_controller.sv
// hazard_fetch_controller: PC redirect, load-use stall, flush and halt sequencing for fetch.
module hazard_fetch_controller
    import mips_pkg::*;
#(
    parameter int AW           = 16,
    parameter int RW           = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex_is_load,
    input  logic [RW-1:0] ex_rd,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rt,
    input  logic          redirect_req,
    input  logic [AW-1:0] redirect_target,
    input  logic          halt_req,
    input  logic          resume,
    output logic [AW-1:0] jmp_loc,
    output logic          pc_mux_sel,
    output logic          stall,
    output logic          stall_pm,
    output logic          flush,
    output logic [15:0]   stall_count,
    output logic [1:0]    state_o
);
    localparam logic [2:0] FC_M1 = 3'(FLUSH_CYCLES - 1);
    logic [1:0]    state, nxt;
    logic [2:0]    cnt, cnt_d;
    logic [AW-1:0] tgt;
    logic          load_use, redir;
    load_use_detect #(.RW(RW)) u_lud (
        .ex_is_load(ex_is_load),
        .ex_rd(ex_rd),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_uses_rt(id_uses_rt),
        .load_use(load_use)
    );
    // Redirect acts in its own cycle; HALT masks it completely.
    assign redir      = redirect_req & (state != ST_HALT);
    assign pc_mux_sel = redir;
    assign jmp_loc    = redir ? redirect_target : tgt;
    assign flush      = redir | (state == ST_FLUSH);
    assign state_o    = state;
    always_comb begin
        nxt   = state;
        cnt_d = cnt;
        if (redir) begin
            nxt   = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
            cnt_d = FC_M1;
        end else begin
            case (state)
                ST_RUN:     nxt = load_use ? ST_LDSTALL : halt_req ? ST_HALT : ST_RUN;
                ST_LDSTALL: nxt = halt_req ? ST_HALT : ST_RUN;
                ST_FLUSH: begin
                    cnt_d = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
                    nxt   = (cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
                end
                default:    nxt = resume ? ST_RUN : ST_HALT;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            cnt         <= 3'd0;
            tgt         <= '0;
            stall       <= 1'b0;
            stall_pm    <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            state       <= nxt;
            cnt         <= cnt_d;
            tgt         <= redir ? redirect_target : tgt;
            stall       <= (nxt == ST_LDSTALL) | (nxt == ST_HALT);
            stall_pm    <= (nxt == ST_LDSTALL) | (nxt == ST_HALT);
            stall_count <= (stall | flush) ? sat_inc(stall_count) : stall_count;
        end
    end
endmodule

// File: tb/tb_hazard_fetch_controller.sv
// tb_hazard_fetch_controller: directed per-cycle vectors with a queued scoreboard checked at negedge.
module tb_hazard_fetch_controller;
    logic        clk, reset, ex_is_load, id_uses_rt, redirect_req, halt_req, resume;
    logic [4:0]  ex_rd, id_rs, id_rt;
    logic [15:0] redirect_target, jmp_loc, stall_count;
    logic        pc_mux_sel, stall, stall_pm, flush;
    logic [1:0]  state_o;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        string       nm;
        logic        pc;
        logic [15:0] jl;
        logic        st;
        logic        fl;
        logic [15:0] cnt;
        logic [1:0]  s;
    } exp_t;
    exp_t q[$];

    hazard_fetch_controller dut (
        .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .redirect_req(redirect_req), .redirect_target(redirect_target),
        .halt_req(halt_req), .resume(resume), .jmp_loc(jmp_loc),
        .pc_mux_sel(pc_mux_sel), .stall(stall), .stall_pm(stall_pm),
        .flush(flush), .stall_count(stall_count), .state_o(state_o)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk(e.nm, "pc_mux_sel", 16'(pc_mux_sel), 16'(e.pc));
                chk(e.nm, "jmp_loc", jmp_loc, e.jl);
                chk(e.nm, "stall", 16'(stall), 16'(e.st));
                chk(e.nm, "stall_pm", 16'(stall_pm), 16'(e.st));
                chk(e.nm, "flush", 16'(flush), 16'(e.fl));
                chk(e.nm, "stall_count", stall_count, e.cnt);
                chk(e.nm, "state_o", 16'(state_o), 16'(e.s));
            end
        end
    end

    task automatic push(input string nm, input logic pc, input logic [15:0] jl, input logic st,
                        input logic fl, input logic [15:0] cnt, input logic [1:0] s);
        exp_t e;
        e.nm = nm; e.pc = pc; e.jl = jl; e.st = st; e.fl = fl; e.cnt = cnt; e.s = s;
        q.push_back(e);
    endtask

    task automatic step(input string nm, input logic rn, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic rr,
                        input logic [15:0] tg, input logic hr, input logic rsm,
                        input logic e_pc, input logic [15:0] e_jl, input logic e_st,
                        input logic e_fl, input logic [15:0] e_cnt, input logic [1:0] e_s);
        @(posedge clk);
        #1;
        reset = rn; ex_is_load = ld; ex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        redirect_req = rr; redirect_target = tg; halt_req = hr; resume = rsm;
        push(nm, e_pc, e_jl, e_st, e_fl, e_cnt, e_s);
    endtask

    task automatic idle(input string nm, input logic [15:0] e_jl, input logic e_st,
                        input logic e_fl, input logic [15:0] e_cnt, input logic [1:0] e_s);
        step(nm, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, e_jl, e_st, e_fl, e_cnt, e_s);
    endtask

    initial begin
        reset = 1'b0; ex_is_load = 0; ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        redirect_req = 0; redirect_target = 0; halt_req = 0; resume = 0;
        push("reset", 0, 16'h0, 0, 0, 16'd0, 2'd0);
        #6 reset = 1'b1;
        // redirect to 0x0005: one comb cycle plus one FLUSH cycle
        idle("run0", 16'h0, 0, 0, 16'd0, 2'd0);
        step("redir5", 1, 0, 0, 0, 0, 0, 1, 16'h0005, 0, 0, 1, 16'h0005, 0, 1, 16'd0, 2'd0);
        idle("flush5", 16'h0005, 0, 1, 16'd1, 2'd2);
        idle("after5", 16'h0005, 0, 0, 16'd2, 2'd0);
        // load-use
        step("rst_a", 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 16'd0, 2'd0);
        step("lu_rs", 1, 1, 5'd3, 5'd3, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 16'd0, 2'd0);
        step("ldstall", 1, 1, 5'd3, 5'd3, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 1, 0, 16'd0, 2'd1);
        step("lu_r0", 1, 1, 5'd0, 5'd0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 16'd1, 2'd0);
        idle("no_stall", 16'h0, 0, 0, 16'd1, 2'd0);
        step("rt_unused", 1, 1, 5'd7, 5'd1, 5'd7, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 16'd1, 2'd0);
        idle("no_stall_rt", 16'h0, 0, 0, 16'd1, 2'd0);
        step("lu_rt", 1, 1, 5'd7, 5'd1, 5'd7, 1, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 16'd1, 2'd0);
        idle("ldstall_rt", 16'h0, 1, 0, 16'd1, 2'd1);
        idle("after_rt", 16'h0, 0, 0, 16'd2, 2'd0);
        // redirect beats a simultaneous load-use
        step("redir_lu", 1, 1, 5'd3, 5'd3, 0, 0, 1, 16'h0020, 0, 0, 1, 16'h0020, 0, 1, 16'd2, 2'd0);
        idle("flush20", 16'h0020, 0, 1, 16'd3, 2'd2);
        idle("after20", 16'h0020, 0, 0, 16'd4, 2'd0);
        // second redirect in FLUSH restarts the count
        step("redir30", 1, 0, 0, 0, 0, 0, 1, 16'h0030, 0, 0, 1, 16'h0030, 0, 1, 16'd4, 2'd0);
        step("redir10", 1, 0, 0, 0, 0, 0, 1, 16'h0010, 0, 0, 1, 16'h0010, 0, 1, 16'd5, 2'd2);
        idle("flush10", 16'h0010, 0, 1, 16'd6, 2'd2);
        idle("after10", 16'h0010, 0, 0, 16'd7, 2'd0);
        // reset mid-FLUSH leaves no residue
        step("redir44", 1, 0, 0, 0, 0, 0, 1, 16'h0044, 0, 0, 1, 16'h0044, 0, 1, 16'd7, 2'd0);
        step("rst_flush", 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 16'd0, 2'd0);
        idle("post_rst", 16'h0, 0, 0, 16'd0, 2'd0);
        // halt for 10 cycles with ignored redirects, then resume
        step("halt_req", 1, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0, 0, 16'h0, 0, 0, 16'd0, 2'd0);
        for (int i = 0; i < 10; i++)
            step($sformatf("halt%0d", i), 1, 0, 0, 0, 0, 0, (i == 1 || i == 4), 16'h0077, 0, (i == 9),
                 0, 16'h0, 1, 0, 16'(i), 2'd3);
        idle("resumed", 16'h0, 0, 0, 16'd10, 2'd0);
        // saturation: counter pinned at max while stalled
        step("halt_b", 1, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0, 0, 16'h0, 0, 0, 16'd10, 2'd0);
        idle("sat_force", 16'h0, 1, 0, 16'hFFFF, 2'd3);
        force dut.stall_count = 16'hFFFF;
        idle("sat_hold", 16'h0, 1, 0, 16'hFFFF, 2'd3);
        release dut.stall_count;
        step("sat_res", 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 1, 0, 16'h0, 1, 0, 16'hFFFF, 2'd3);
        idle("sat_run", 16'h0, 0, 0, 16'hFFFF, 2'd0);
        // reset while halted
        step("halt_c", 1, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0, 0, 16'h0, 0, 0, 16'hFFFF, 2'd0);
        step("rst_halt", 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 16'd0, 2'd0);
        idle("post_rst2", 16'h0, 0, 0, 16'd0, 2'd0);
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_fetch_controller.md
HAZARD_FETCH_CONTROLLER -- requirements
Module: hazard_fetch_controller

Interface
REQ-001 SHALL have parameter AW, default 16, meaning program address width and jmp_loc width.
REQ-002 SHALL have parameter RW, default 5, meaning register-specifier width.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..7, meaning the number of bubble cycles after a redirect.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ex_is_load, input, 1 bit: the instruction in EX is a load.
REQ-007 SHALL have port ex_rd, input, RW bits: destination register of the EX instruction.
REQ-008 SHALL have ports id_rs and id_rt, input, RW bits each: source registers of the ID instruction.
REQ-009 SHALL have port id_uses_rt, input, 1 bit: the ID instruction reads rt.
REQ-010 SHALL have port redirect_req, input, 1 bit: a taken branch or jump has resolved in EX.
REQ-011 SHALL have port redirect_target, input, AW bits: the target address for redirect_req.
REQ-012 SHALL have port halt_req, input, 1 bit: the halt instruction is in ID.
REQ-013 SHALL have port resume, input, 1 bit: leave the halted state.
REQ-014 SHALL have port jmp_loc, output, AW bits: target address to program_memory.
REQ-015 SHALL have port pc_mux_sel, output, 1 bit: 1 loads jmp_loc into the PC, 0 selects the sequential PC.
REQ-016 SHALL have port stall, output, 1 bit: hold the PC.
REQ-017 SHALL have port stall_pm, output, 1 bit: hold the program_memory ins register.
REQ-018 SHALL have port flush, output, 1 bit: replace the ID instruction with a NOP.
REQ-019 SHALL have port stall_count, output, 16 bits: saturating count of stall plus flush cycles.
REQ-020 SHALL have port state_o, output, 2 bits: current FSM state encoding.

Function
REQ-021 SHALL implement FSM states RUN=0, LDSTALL=1, FLUSH=2 and HALT=3, all registered.
REQ-022 SHALL compute load_use = ex_is_load & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)) combinationally.
REQ-023 SHALL apply this event priority in every state except HALT: redirect_req > load_use > halt_req.
REQ-024 SHALL, when redirect_req is high, drive pc_mux_sel=1, drive jmp_loc=redirect_target and assert flush in the same cycle, capture redirect_target, load the flush counter with FLUSH_CYCLES-1, and go to FLUSH; if FLUSH_CYCLES==1, it SHALL return to RUN instead.
REQ-025 SHALL, in FLUSH, assert flush, hold pc_mux_sel=0 and decrement the counter each cycle, returning to RUN when the counter reaches 0, for a total of exactly FLUSH_CYCLES flush cycles.
REQ-026 SHALL treat a redirect_req arriving while in FLUSH as a new redirect that restarts the count.
REQ-027 SHALL, on load_use in RUN, assert stall=1 and stall_pm=1 for exactly one cycle (the LDSTALL state) and then return to RUN; a load_use already present on entry to LDSTALL SHALL NOT re-trigger the stall.
REQ-028 SHALL, on halt_req in RUN, go to HALT with stall=1 and stall_pm=1 held continuously.
REQ-029 SHALL leave HALT only on resume (to RUN) or on reset, and SHALL ignore redirect_req while in HALT.
REQ-030 SHALL drive, in RUN with no event: pc_mux_sel=0, stall=0, stall_pm=0, flush=0, and jmp_loc equal to the last captured target.
REQ-031 SHALL increment stall_count on every cycle in which stall or flush is asserted, saturating at 16'hFFFF.
REQ-032 SHALL generate all outputs except jmp_loc, pc_mux_sel and flush from registers; those three SHALL follow redirect_req combinationally in the redirect cycle.

Reset
REQ-033 SHALL, while reset=0, immediately force state=RUN, flush counter=0, captured target=0 (so jmp_loc=0), pc_mux_sel=0, stall=0, stall_pm=0, flush=0 and stall_count=0.
REQ-034 SHALL let reset asserted mid-FLUSH or in HALT abandon the operation with no residual flush or stall cycles.
REQ-035 SHALL act on the first rising clk edge after reset deasserts.

Structure
REQ-036 SHALL place the state encodings and the NOP instruction constant in the shared package mips_pkg.
REQ-037 SHALL contain one sub-module, load_use_detect, which holds the purely combinational comparator of REQ-022.

Verification
REQ-038 SHALL check the reset pulse: reset=0 for 6 ns, then 1 -> all outputs 0 and state_o=0 throughout reset.
REQ-039 SHALL check a redirect: redirect_req=1 with target 16'h0005 for one cycle -> pc_mux_sel=1 and jmp_loc=16'h0005 that cycle, flush high for exactly 2 cycles, then RUN.
REQ-040 SHALL check load-use: ex_is_load=1, ex_rd=3, id_rs=3 -> stall=1 and stall_pm=1 for one cycle and stall_count=1; a repeat with ex_rd=0 -> no stall.
REQ-041 SHALL check simultaneous events: redirect_req and load_use in the same cycle -> redirect path taken with no LDSTALL.
REQ-042 SHALL check halt: halt_req -> stall held for 10 cycles while redirect_req pulses are ignored; resume -> RUN with stall_count=10.
REQ-043 SHALL check a second redirect to 16'h0010 during FLUSH -> jmp_loc=16'h0010 and 2 fresh flush cycles; force stall_count=16'hFFFF -> it stays at 16'hFFFF.
